// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths and phase-accumulator state enum.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dds_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_phase_acc_if.sv
// Control/sample bundle between the frequency-select stage, the phase accumulator and the ROM.
// Latency: none (wiring only).
// Backpressure: none; samples are qualified by addr_vld and cannot be stalled except via en.
interface dds_phase_acc_if
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ACC_W-1:0]  inc;
  logic              en;
  logic              sync_clr;
  logic [ADDR_W-1:0] pha_ofs;
  logic [ADDR_W-1:0] addr;
  logic              addr_vld;
  logic              wrap;
  logic [ACC_W-1:0]  inc_act;
  logic              chg_pend;

  // Controller side: drives frequency word and controls, observes samples.
  modport master (
    output inc, en, sync_clr, pha_ofs,
    input  addr, addr_vld, wrap, inc_act, chg_pend
  );

  // Accumulator side.
  modport slave (
    input  inc, en, sync_clr, pha_ofs,
    output addr, addr_vld, wrap, inc_act, chg_pend
  );

endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator: steps by inc_act, swaps increment only at a phase wrap, adds phase offset.
// Latency: a step taken at edge k is visible on addr/addr_vld/wrap after edge k+1.
// Backpressure: none; en=0 freezes phase and suppresses addr_vld/wrap.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dds_phase_acc_if.slave   bus
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc_act;
  dds_state_e        state;
  logic              chg_pend_q;
  logic              step_q;
  logic              carry_q;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_vld_q;
  logic              wrap_q;

  // Full-width add so the carry-out marks the phase wrap.
  assign sum   = {1'b0, acc} + {1'b0, inc_act};
  assign carry = sum[ACC_W];

  // Accumulator and increment-swap state machine; a new increment is only
  // adopted on a carrying step so the waveform stays phase-continuous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      inc_act    <= '0;
      state      <= IDLE;
      chg_pend_q <= 1'b0;
      step_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else if (bus.sync_clr) begin
      acc        <= '0;
      inc_act    <= bus.inc;
      state      <= (bus.inc == '0) ? IDLE : RUN;
      chg_pend_q <= 1'b0;
      step_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      step_q  <= bus.en;
      carry_q <= bus.en & carry;
      if (bus.en) begin
        acc <= sum[ACC_W-1:0];
      end
      case (state)
        IDLE: begin
          // A zero increment never wraps, so load immediately.
          if (bus.inc != '0) begin
            inc_act <= bus.inc;
            state   <= RUN;
          end
        end
        RUN, PEND: begin
          if (bus.en && carry) begin
            // This edge's step still used the old increment.
            inc_act    <= bus.inc;
            state      <= (bus.inc == '0) ? IDLE : RUN;
            chg_pend_q <= 1'b0;
          end else if ((state == RUN) && (bus.inc != inc_act)) begin
            state      <= PEND;
            chg_pend_q <= 1'b1;
          end else if ((state == PEND) && (bus.inc == inc_act)) begin
            state      <= RUN;
            chg_pend_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          chg_pend_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register: phase address with offset, plus sample/wrap pulses
  // for the step taken one edge earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (bus.sync_clr) begin
      addr_q     <= bus.pha_ofs;
      addr_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      addr_vld_q <= step_q;
      wrap_q     <= carry_q;
      if (step_q) begin
        addr_q <= acc[ACC_W-1 -: ADDR_W] + bus.pha_ofs;
      end
    end
  end

  assign bus.addr     = addr_q;
  assign bus.addr_vld = addr_vld_q;
  assign bus.wrap     = wrap_q;
  assign bus.inc_act  = inc_act;
  assign bus.chg_pend = chg_pend_q;

endmodule

// File: doc/dds_phase_acc.md
# dds_phase_acc

Phase accumulator stage of the DDS chain. Consumes the registered frequency-control word from the frequency-select stage and produces a phase address for the sine lookup ROM. Increment changes are applied only at a phase wrap, so the output waveform stays phase-continuous with no glitch when `sel` changes. Adds a programmable phase offset and flags each wrap for downstream sync.

## Interface
- `ACC_W`, 32: accumulator width; equals the frequency-word width.
- `ADDR_W`, 10: ROM address width; must satisfy 1 ≤ `ADDR_W` ≤ `ACC_W`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inc`  in  ACC_W  frequency-control word from the frequency-select stage; quasi-static.
- `en`  in  1  accumulate enable; low holds phase.
- `sync_clr`  in  1  synchronous phase clear.
- `pha_ofs`  in  ADDR_W  phase offset added to the address.
- `addr`  out  ADDR_W  ROM phase address.
- `addr_vld`  out  1  `addr` holds a new sample.
- `wrap`  out  1  accumulator carry-out for the step shown on `addr`.
- `inc_act`  out  ACC_W  increment currently in use.
- `chg_pend`  out  1  increment change waiting for the next wrap.

## Operation
- Reset values: `acc`=0, `inc_act`=0, state IDLE, `addr`=0, `addr_vld`=0, `wrap`=0, `chg_pend`=0.
- Step: on an edge with `en`=1 and `sync_clr`=0, `acc` ← (`acc` + `inc_act`) mod 2^ACC_W.
  - carry = carry-out of that ACC_W-bit add.
- Address: `addr` ← (`acc_new`[ACC_W-1 -: ADDR_W] + `pha_ofs`) mod 2^ADDR_W.
  - Computed from the post-step accumulator; offset add discards its carry.
- State machine (`chg_pend` = state==PEND):
  - IDLE (`inc_act`==0): if `inc`≠0, then `inc_act` ← `inc` and go to RUN. The load is immediate; a zero increment would never reach a wrap.
  - RUN: if `inc`≠`inc_act` on a non-wrap edge, go to PEND.
  - PEND:
    - If `inc`==`inc_act` again, cancel and return to RUN.
    - Further changes of `inc` stay in PEND; the last value wins.
  - Wrap edge (step with carry=1, in RUN or PEND): `inc_act` ← current `inc`. Next state is IDLE if `inc`==0, else RUN. The step on that edge uses the old `inc_act`.
- `en`=0:
  - `acc`, `inc_act`, and `addr` hold; `addr_vld`=0 and `wrap`=0.
  - State transitions that do not need a wrap still occur, so IDLE→RUN and PEND→RUN cancel remain active.
- `sync_clr`=1 (priority over `en`):
  - `acc` ← 0, `inc_act` ← `inc`, state ← IDLE/RUN according to `inc`==0.
  - `addr` ← `pha_ofs`, `addr_vld` ← 0, `wrap` ← 0.
- `rst` asserted mid-operation: all registers return to reset values immediately (asynchronous); no partial step survives.

## Timing
- Latency: the step at edge k appears on `addr`/`addr_vld`/`wrap` after edge k+1. One accumulator register plus one output register.
- `wrap` and `addr_vld` are single-cycle pulses aligned with the sample of the carrying step.
- IDLE load at edge k: the first step using the new `inc_act` occurs at edge k+1.
- Change request at edge k in RUN: `chg_pend`=1 after edge k. It clears after the wrap edge or the cancel edge.
- `inc_act` updates on the wrap edge itself. The sample carrying `wrap`=1 was computed with the old increment; the following sample uses the new one.
- Throughput: one sample per cycle while `en`=1.

## Structure
- Shared package `dds_pkg`: default `ACC_W`/`ADDR_W` constants and the state enum (IDLE, RUN, PEND), reused by the ROM and frequency-select stages.
- Single module, no sub-module. The offset adder is one registered expression.

## Test plan
- Reset, then `inc`=32'h4000_0000, `pha_ofs`=0, `en`=1:
  - `inc_act` loads on the first edge.
  - `addr` = 0x100, 0x200, 0x300, 0x000 with `wrap`=1 only on 0x000; the sequence repeats.
- Same setup, with `inc` changed to 32'h8000_0000 after the 0x100 sample:
  - `chg_pend`=1 and samples continue 0x200, 0x300, 0x000 (wrap).
  - Then 0x200, 0x000 (wrap), with `chg_pend`=0.
- PEND cancel: change `inc` to 32'h8000_0000 and back to 32'h4000_0000 before the wrap → `chg_pend` returns to 0 and the 0x100-step sequence is unbroken.
- `pha_ofs`=10'h3FF with `inc`=32'h4000_0000 → `addr` = 0x0FF, 0x1FF, 0x2FF, 0x3FF (wrap).
- `en` held low 5 cycles mid-sequence → `addr` frozen and `addr_vld`=0 during the hold; on resume, the sequence continues from the frozen phase.
- `sync_clr` pulse in PEND → after the clear, `addr`=`pha_ofs`, `chg_pend`=0, and `inc_act`=new `inc`. An async `rst` mid-run → all outputs 0 within the same cycle.
